// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types and constants for the EX issue controller slice.
//   ex_issue_state_e : issue FSM states (idle / multi-cycle / waiting on writeback)
//   IMD_VAL_W        : width of each intermediate-value register bank
package ibex_pkg;

    localparam int unsigned IMD_VAL_W = 34;

    typedef enum logic [1:0] {
        EX_IDLE    = 2'd0,
        EX_MULTI   = 2'd1,
        EX_WAIT_WB = 2'd2
    } ex_issue_state_e;

endpackage

// File: rtl/ibex_imd_val_reg.sv
// ibex_imd_val_reg: two intermediate-value banks written by the EX block.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset (clears both banks)
//   we_i          : per-bank write enable
//   d_i           : per-bank write data
//   q_o           : per-bank stored value
module ibex_imd_val_reg
    import ibex_pkg::*;
#(
    parameter int unsigned ImdValW = IMD_VAL_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [1:0]             we_i,
    input  logic [1:0][ImdValW-1:0] d_i,
    output logic [1:0][ImdValW-1:0] q_o
);

    logic [1:0][ImdValW-1:0] imd_d, imd_q;

    always_comb begin
        imd_d = imd_q;
        for (int k = 0; k < 2; k++) begin
            if (we_i[k]) imd_d[k] = d_i[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) imd_q <= '0;
        else         imd_q <= imd_d;
    end

    assign q_o = imd_q;

endmodule

// File: rtl/ibex_ex_issue_ctrl.sv
// ibex_ex_issue_ctrl: ID-side issue controller for the execution block.
// Sequences single- and multi-cycle ALU/MUL/DIV instructions, owns the
// intermediate-value registers, and stalls ID until writeback takes the result.
// Ports:
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   instr_valid_i, flush_i   : instruction present / kill it
//   mult_sel_i, div_sel_i    : static decoder selects
//   ex_valid_i, wb_ready_i   : EX result valid / writeback accepts it
//   imd_val_we_i/_d_i/_q_o   : intermediate-value register access from EX
//   mult_en_o, div_en_o      : dynamic enables, held until retirement
//   alu_instr_first_cycle_o  : first EX cycle of the instruction
//   multdiv_ready_id_o       : ID can consume the mult/div result
//   instr_done_o, stall_o    : retirement pulse / hold ID
// Optional: define IBEX_EX_ISSUE_PERF_EN to add stall_cycles_o, a saturating
// count of stalled cycles.
module ibex_ex_issue_ctrl
    import ibex_pkg::*;
#(
    parameter bit          RV32M   = 1'b1,
    parameter int unsigned ImdValW = IMD_VAL_W
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_valid_i,
    input  logic                    mult_sel_i,
    input  logic                    div_sel_i,
    input  logic                    flush_i,
    input  logic                    wb_ready_i,
    input  logic                    ex_valid_i,
    input  logic [1:0]              imd_val_we_i,
    input  logic [1:0][ImdValW-1:0] imd_val_d_i,
    output logic [1:0][ImdValW-1:0] imd_val_q_o,
    output logic                    mult_en_o,
    output logic                    div_en_o,
    output logic                    alu_instr_first_cycle_o,
    output logic                    multdiv_ready_id_o,
    output logic                    instr_done_o,
    output logic                    stall_o
`ifdef IBEX_EX_ISSUE_PERF_EN
    ,
    output logic [31:0]             stall_cycles_o
`endif
);

    ex_issue_state_e state_d, state_q;
    logic            go, done;
    logic [1:0]      imd_we;

    assign go   = instr_valid_i & ~flush_i;
    assign done = go & ex_valid_i & wb_ready_i;

    // A flush (or valid dropping) kills the instruction: EX must not update
    // its intermediate state on behalf of a dead instruction.
    assign imd_we = {2{go}} & imd_val_we_i;

    assign multdiv_ready_id_o = wb_ready_i;

    always_comb begin
        state_d                 = state_q;
        mult_en_o               = 1'b0;
        div_en_o                = 1'b0;
        alu_instr_first_cycle_o = 1'b0;
        instr_done_o            = 1'b0;
        stall_o                 = 1'b0;

        if (!go || done) begin
            state_d = EX_IDLE;
        end else if (ex_valid_i) begin
            state_d = EX_WAIT_WB;
        end else if (state_q != EX_WAIT_WB) begin
            state_d = EX_MULTI;
        end

        if (rst_ni) begin
            mult_en_o               = RV32M & go & mult_sel_i;
            div_en_o                = RV32M & go & div_sel_i;
            alu_instr_first_cycle_o = go & (state_q == EX_IDLE);
            instr_done_o            = done;
            stall_o                 = go & ~done;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= EX_IDLE;
        else         state_q <= state_d;
    end

    ibex_imd_val_reg #(
        .ImdValW (ImdValW)
    ) u_imd_val_reg (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we_i   (imd_we),
        .d_i    (imd_val_d_i),
        .q_o    (imd_val_q_o)
    );

`ifdef IBEX_EX_ISSUE_PERF_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cycles_o = stall_cnt_q;
`endif

endmodule
